// File: rtl/shift_sequencer_if.sv
// Signal bundle between the pipeline/bench, the shift sequencer and the
// single-bit LHS shift unit. The slave modport is the sequencer's view.
interface shift_sequencer_if #(
  parameter int COUNT_W = 4
);
  // request / response
  logic               start;
  logic [2:0]         op;
  logic [COUNT_W-1:0] count;
  logic [7:0]         data_in;
  logic               carry_in;
  logic               busy;
  logic               done;
  logic [7:0]         result;
  logic               carry_result;
  // pipeline-side shift unit controls
  logic               pipe_sel_a;
  logic               pipe_sel_b;
  logic               pipe_carry;
  logic [7:0]         pipe_lhs;
  // shift unit drive and registered return
  logic               sh_sel_a;
  logic               sh_sel_b;
  logic               sh_carry_in;
  logic [7:0]         sh_lhs_in;
  logic               sh_carry_out;
  logic [7:0]         sh_lhs_out;

  modport slave (
    input  start, op, count, data_in, carry_in,
    input  pipe_sel_a, pipe_sel_b, pipe_carry, pipe_lhs,
    input  sh_carry_out, sh_lhs_out,
    output busy, done, result, carry_result,
    output sh_sel_a, sh_sel_b, sh_carry_in, sh_lhs_in
  );

  modport master (
    output start, op, count, data_in, carry_in,
    output pipe_sel_a, pipe_sel_b, pipe_carry, pipe_lhs,
    output sh_carry_out, sh_lhs_out,
    input  busy, done, result, carry_result,
    input  sh_sel_a, sh_sel_b, sh_carry_in, sh_lhs_in
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift/rotate sequencer in front of a single-bit LHS shift unit.
// Issues one single-bit step per clock, feeding the unit's registered output
// back in, and shares the unit with the pipeline while idle.
module shift_sequencer #(
  parameter int COUNT_W   = 4,
  parameter int MAX_STEPS = 8
) (
  input logic             clk,
  input logic             rst_n,
  shift_sequencer_if.slave bus
);

  localparam logic [2:0] OP_SHL = 3'd0, OP_SHR = 3'd1, OP_ROL = 3'd2, OP_ROR = 3'd3,
                         OP_RCL = 3'd4, OP_RCR = 3'd5, OP_ASR = 3'd6, OP_CLR = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  typedef struct packed {
    logic [2:0]         op;
    logic [7:0]         data;
    logic               carry;
    logic [COUNT_W-1:0] steps;
    logic               pass;   // count was 0: one pass step, carry flag preserved
  } req_t;

  state_t             state, state_nx;
  req_t               req;
  logic [COUNT_W-1:0] step;
  logic [COUNT_W-1:0] steps_in;
  logic [7:0]         result_q;
  logic               carry_q;
  logic               done_q;

  logic               sel_a, sel_b, cin;
  logic [7:0]         lhs, cur_v;
  logic               cur_c;

  // Step count for an incoming request: count 0 and CLR both take one step.
  always_comb begin
    steps_in = bus.count;
    if (bus.count == '0 || bus.op == OP_CLR)
      steps_in = COUNT_W'(1);
    else if (bus.count > COUNT_W'(MAX_STEPS))
      steps_in = COUNT_W'(MAX_STEPS);
  end

  // Next state and shift-unit drive; passthrough to the pipeline while idle.
  always_comb begin
    state_nx = state;
    sel_a    = bus.pipe_sel_a;
    sel_b    = bus.pipe_sel_b;
    cin      = bus.pipe_carry;
    lhs      = bus.pipe_lhs;
    cur_v    = (step == COUNT_W'(1)) ? req.data  : bus.sh_lhs_out;
    cur_c    = (step == COUNT_W'(1)) ? req.carry : bus.sh_carry_out;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: begin
        lhs   = cur_v;
        cin   = 1'b0;
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (!req.pass) begin
          case (req.op)
            OP_SHL: sel_a = 1'b1;
            OP_SHR: sel_b = 1'b1;
            OP_ROL: begin sel_a = 1'b1; cin = cur_v[7]; end
            OP_ROR: begin sel_b = 1'b1; cin = cur_v[0]; end
            OP_RCL: begin sel_a = 1'b1; cin = cur_c;    end
            OP_RCR: begin sel_b = 1'b1; cin = cur_c;    end
            OP_ASR: begin sel_b = 1'b1; cin = cur_v[7]; end
            default: begin sel_a = 1'b1; sel_b = 1'b1; end
          endcase
        end
        if (step == req.steps) state_nx = CAPTURE;
      end
      CAPTURE: begin
        // unit still owned; a harmless pass keeps it quiet
        lhs      = bus.sh_lhs_out;
        cin      = 1'b0;
        sel_a    = 1'b0;
        sel_b    = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch, step counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req          <= '0;
      step         <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          req.op    <= bus.op;
          req.data  <= bus.data_in;
          req.carry <= bus.carry_in;
          req.steps <= steps_in;
          req.pass  <= (bus.count == '0);
          step      <= COUNT_W'(1);
        end
        RUN: if (step != req.steps) step <= step + COUNT_W'(1);
        CAPTURE: begin
          result_q <= bus.sh_lhs_out;
          carry_q  <= req.pass ? req.carry : bus.sh_carry_out;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.carry_result = carry_q;
  assign bus.sh_sel_a     = sel_a;
  assign bus.sh_sel_b     = sel_b;
  assign bus.sh_carry_in  = cin;
  assign bus.sh_lhs_in    = lhs;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural single-bit shift unit, closed-form
// reference for every op, directed plan cases followed by random requests.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer_if #(.COUNT_W(4)) bus ();

  shift_sequencer #(.COUNT_W(4), .MAX_STEPS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Single-bit LHS shift unit: registered, no reset.
  always @(posedge clk) begin
    case ({bus.sh_sel_b, bus.sh_sel_a})
      2'b00: begin bus.sh_lhs_out <= bus.sh_lhs_in; bus.sh_carry_out <= 1'b0; end
      2'b01: begin bus.sh_lhs_out <= {bus.sh_lhs_in[6:0], bus.sh_carry_in}; bus.sh_carry_out <= bus.sh_lhs_in[7]; end
      2'b10: begin bus.sh_lhs_out <= {bus.sh_carry_in, bus.sh_lhs_in[7:1]}; bus.sh_carry_out <= bus.sh_lhs_in[0]; end
      default: begin bus.sh_lhs_out <= 8'h00; bus.sh_carry_out <= 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form result of a whole multi-bit operation.
  function automatic void model(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d,
                                input logic ci, output logic [7:0] r, output logic rc, output int n);
    int k;
    logic [15:0] w;
    logic signed [15:0] ws;
    logic [17:0] w9;
    k = (c > 4'd8) ? 8 : int'(c);
    n = (o == 3'd7 || c == 4'd0) ? 1 : k;
    r = 8'h00; rc = 1'b0;
    if (c == 4'd0) begin
      r = d; rc = ci;
    end else begin
      case (o)
        3'd0: begin w = {8'h00, d} << k; r = w[7:0];  rc = w[8]; end
        3'd1: begin w = {d, 8'h00} >> k; r = w[15:8]; rc = w[7]; end
        3'd2: begin w = {d, d} << k;     r = w[15:8]; rc = r[0]; end
        3'd3: begin w = {d, d} >> k;     r = w[7:0];  rc = r[7]; end
        3'd4: begin w9 = {ci, d, ci, d} << k; r = w9[16:9]; rc = w9[17]; end
        3'd5: begin w9 = {ci, d, ci, d} >> k; r = w9[7:0];  rc = w9[8];  end
        3'd6: begin ws = {d, 8'h00}; ws = ws >>> k; r = ws[15:8]; rc = ws[7]; end
        default: begin r = 8'h00; rc = 1'b0; end
      endcase
    end
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d,
                        input logic ci, input bit poke);
    logic [7:0] er;
    logic       ec;
    int         n, cyc, iss, extra;
    model(o, c, d, ci, er, ec, n);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.count = c; bus.data_in = d; bus.carry_in = ci;
    @(negedge clk);
    bus.start = 1'b0; bus.data_in = 8'($urandom); bus.carry_in = 1'($urandom);
    check("busy_after_accept", bus.busy, 1);
    cyc = 0; iss = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy && {bus.sh_sel_b, bus.sh_sel_a} != 2'b00) iss++;
      bus.pipe_sel_a = 1'($urandom); bus.pipe_sel_b = 1'($urandom);
      bus.pipe_carry = 1'($urandom); bus.pipe_lhs = 8'($urandom);
      if (poke && cyc == 2) begin
        bus.start = 1'b1; bus.op = 3'd0; bus.count = 4'd1; bus.data_in = 8'hA5;
      end else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_latency", cyc, n + 1);
    check("result", bus.result, er);
    check("carry_result", bus.carry_result, ec);
    check("issue_cycles", iss, (c == 4'd0) ? 0 : n);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    if (poke) begin
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      check("ignored_start", extra, 0);
    end
  endtask

  initial begin
    int bad_done;
    logic [2:0] ro;
    logic [3:0] rc;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.count = '0; bus.data_in = '0; bus.carry_in = 1'b0;
    bus.pipe_sel_a = 1'b0; bus.pipe_sel_b = 1'b0; bus.pipe_carry = 1'b0; bus.pipe_lhs = '0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle passthrough
    @(negedge clk);
    bus.pipe_sel_a = 1'b1; bus.pipe_sel_b = 1'b0; bus.pipe_carry = 1'b1; bus.pipe_lhs = 8'h33;
    #1;
    check("pass_sel", {bus.sh_sel_b, bus.sh_sel_a}, 2'b01);
    check("pass_lhs", bus.sh_lhs_in, 8'h33);
    check("pass_carry", bus.sh_carry_in, 1);

    // directed plan cases
    run_op(3'd0, 4'd1,  8'h81, 1'b0, 1'b0);   // SHL
    run_op(3'd3, 4'd3,  8'h01, 1'b0, 1'b0);   // ROR
    run_op(3'd4, 4'd2,  8'h80, 1'b0, 1'b0);   // RCL
    run_op(3'd6, 4'd3,  8'h80, 1'b0, 1'b0);   // ASR
    run_op(3'd0, 4'd0,  8'h5A, 1'b1, 1'b0);   // count 0 keeps flag
    run_op(3'd7, 4'd5,  8'hFF, 1'b1, 1'b0);   // CLR
    run_op(3'd1, 4'd12, 8'hFF, 1'b0, 1'b0);   // SHR clamped to 8
    run_op(3'd2, 4'd5,  8'hC3, 1'b0, 1'b1);   // ROL with ignored second start

    // reset during step 3 of an 8-step SHL
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.count = 4'd8; bus.data_in = 8'hFF; bus.carry_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    bus.pipe_sel_a = 1'b0; bus.pipe_sel_b = 1'b1; bus.pipe_lhs = 8'h6C; bus.pipe_carry = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_pass_sel", {bus.sh_sel_b, bus.sh_sel_a}, 2'b10);
    check("abort_pass_lhs", bus.sh_lhs_in, 8'h6C);
    @(negedge clk);
    rst_n = 1'b1;
    bad_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad_done++;
    end
    check("abort_no_done", bad_done, 0);
    check("abort_result", bus.result, 0);
    run_op(3'd2, 4'd1, 8'h80, 1'b0, 1'b0);    // fresh ROL after reset

    // random requests
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rc = 4'($urandom_range(0, 15));
      if (ro == 3'd7 && rc == 4'd0) rc = 4'd1;
      run_op(ro, rc, 8'($urandom), 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
